// File: rtl/wb_queue.sv
// Write-back queue: selects the retiring write-back value, holds it in an
// in-order DEPTH-entry FIFO that drains to the memory write path, and offers
// an address-match forwarding lookup over the occupied entries.
// DEPTH must be a power of two and at least 2.

// One queue slot: stored {data, addr, is_stack} plus its forwarding comparator.
module wb_queue_entry #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] waddr,
    input  logic          wstk,
    input  logic [AW-1:0] fwd_addr,
    output logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          stk,
    output logic          match
);

    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          stk_q,  stk_d;

    // Load the slot only when the tail points here and a push happens.
    always_comb begin
        data_d = data_q;
        addr_d = addr_q;
        stk_d  = stk_q;
        if (we) begin
            data_d = wdata;
            addr_d = waddr;
            stk_d  = wstk;
        end
    end

    // Slot storage; reset clears the contents, not just the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            addr_q <= '0;
            stk_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            addr_q <= addr_d;
            stk_q  <= stk_d;
        end
    end

    assign data  = data_q;
    assign addr  = addr_q;
    assign stk   = stk_q;
    // Occupancy is qualified by the parent; this is the raw address compare.
    assign match = (addr_q == fwd_addr);

endmodule

module wb_queue #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     dsp,
    input  logic                     ern,
    input  logic                     mem_load,
    input  logic [DW-1:0]            pc_buf,
    input  logic [DW-1:0]            alu_buf,
    input  logic [DW-1:0]            ld_data,
    input  logic [AW-1:0]            wr_addr,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [DW-1:0]            wb_data,
    output logic [AW-1:0]            wb_addr,
    output logic                     wb_is_stack,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            fwd_addr,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;

    logic          push, pop;
    logic          full, empty;
    logic [CW-1:0] occ;

    logic [DW-1:0] sel_data;
    logic          sel_stk;

    logic [DW-1:0] ent_data  [DEPTH];
    logic [AW-1:0] ent_addr  [DEPTH];
    logic          ent_stk   [DEPTH];
    logic          ent_match [DEPTH];
    logic          ent_we    [DEPTH];

    logic [PW-1:0] head_idx;
    logic [PW-1:0] fwd_idx;

    // Source select: a stack write wins unless ERN suppresses it, then load, then ALU.
    always_comb begin
        sel_data = alu_buf;
        sel_stk  = 1'b0;
        if (dsp && !ern) begin
            sel_data = pc_buf;
            sel_stk  = 1'b1;
        end else if (mem_load) begin
            sel_data = ld_data;
        end
    end

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) &&
                      (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign occ      = wr_ptr_q - rd_ptr_q;

    // Ready and valid come from registered state only; no wb_ready -> in_ready path.
    assign in_ready = !full;
    assign wb_valid = !empty;
    assign count    = occ;

    assign push     = in_valid && in_ready;
    assign pop      = wb_valid && wb_ready;

    // Pointer advance; both may move in the same cycle for full throughput.
    always_comb begin
        wr_ptr_d = wr_ptr_q + CW'(push);
        rd_ptr_d = rd_ptr_q + CW'(pop);
    end

    // Pointer registers; a push or pop coincident with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_ent
            assign ent_we[g] = push && (wr_ptr_q[PW-1:0] == PW'(g));
            wb_queue_entry #(.DW(DW), .AW(AW)) u_ent (
                .clk      (clk),
                .rst      (rst),
                .we       (ent_we[g]),
                .wdata    (sel_data),
                .waddr    (wr_addr),
                .wstk     (sel_stk),
                .fwd_addr (fwd_addr),
                .data     (ent_data[g]),
                .addr     (ent_addr[g]),
                .stk      (ent_stk[g]),
                .match    (ent_match[g])
            );
        end
    endgenerate

    assign head_idx = rd_ptr_q[PW-1:0];

    // Head outputs are forced to zero when the queue is empty.
    always_comb begin
        wb_data     = '0;
        wb_addr     = '0;
        wb_is_stack = 1'b0;
        if (wb_valid) begin
            wb_data     = ent_data[head_idx];
            wb_addr     = ent_addr[head_idx];
            wb_is_stack = ent_stk[head_idx];
        end
    end

    // Forwarding: walk occupied slots oldest to youngest so the youngest match
    // wins. Uses registered occupancy, so this cycle's push is not visible while
    // the entry being popped still is.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_idx + PW'(k);
            if ((CW'(k) < occ) && ent_match[fwd_idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[fwd_idx];
            end
        end
    end

endmodule

// File: doc/wb_queue.md
# wb_queue

Parametrised write-back stage for the pipelined processor. It selects the write-back value for each retiring instruction and holds it in a DEPTH-entry in-order queue. The queue drains into the 3-port memory data write path through a valid/ready handshake. Sources are the stage 3-4 PC buffer (for DSP stack writes), the ALU result and load data. An address-match forwarding port lets earlier stages read values that are queued but not yet written.

## Interface
Parameters:
- DW, 16: data width of every data path.
- AW, 16: write address width.
- DEPTH, 4: queue entries; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  a retiring instruction presents a write-back.
- in_ready  out  1  queue can accept; equals !full.
- dsp  in  1  DSP bit from CCG 4, marks a stack write.
- ern  in  1  ERN from CCG 4.
- mem_load  in  1  instruction is a load; select ld_data.
- pc_buf  in  DW  PC buffer value from the stage 3-4 buffer.
- alu_buf  in  DW  ALU stage output.
- ld_data  in  DW  load data.
- wr_addr  in  AW  destination address for the write.
- wb_valid  out  1  head entry is valid (!empty).
- wb_ready  in  1  memory write path accepts the head entry.
- wb_data  out  DW  head data.
- wb_addr  out  AW  head address.
- wb_is_stack  out  1  head entry came from the PC path.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- fwd_addr  in  AW  lookup address.
- fwd_hit  out  1  some queued entry matches fwd_addr.
- fwd_data  out  DW  data of the youngest matching entry.

## Operation
Source select is combinational, with priority in this order:
- dsp && !ern: pc_buf, with is_stack=1.
- else if mem_load: ld_data, with is_stack=0.
- else: alu_buf, with is_stack=0.
- dsp && ern falls through to the mem_load/alu rules.

Queue behaviour:
- Push when in_valid && in_ready. The entry {data, addr, is_stack} is written at the tail, and the tail pointer increments modulo DEPTH.
- Pop when wb_valid && wb_ready. The head pointer increments modulo DEPTH.
- Pointers are log2(DEPTH)+1 bits wide. The MSB difference distinguishes full from empty:
  - empty: pointers are equal.
  - full: low bits are equal and the MSBs differ.
- Simultaneous push and pop while neither full nor empty: count is unchanged and both pointers advance.
- Push while empty with a simultaneous wb_ready: no bypass. The entry becomes visible the next cycle and pops no earlier than that.
- Push while full: impossible, because in_ready=0. An in_valid presented while full is ignored; the source must hold it.
- Pop while empty: ignored, because wb_valid=0.
- When wb_valid=0, wb_data, wb_addr and wb_is_stack are driven to 0.

Forwarding is combinational:
- Compare fwd_addr against every occupied entry.
- fwd_data is the data of the matching entry nearest the tail (youngest).
- When there is no hit, fwd_hit=0 and fwd_data=0.
- Entries being pushed in the current cycle are not searched.
- An entry being popped in the current cycle is still searched.

Reset:
- Pointers and count go to 0.
- All stored entries are cleared to 0.
- Outputs after reset: wb_valid=0, in_ready=1, wb_data=0, wb_addr=0, wb_is_stack=0, fwd_hit=0, fwd_data=0.
- Reset mid-operation discards all queued entries. A push or pop in the reset cycle has no effect.

## Timing
- Latency from push to head visibility: 1 cycle when the queue is empty. Otherwise the entry waits behind older entries.
- Throughput: 1 push and 1 pop per cycle sustained.
- count, in_ready and wb_valid update on the clock edge after the push or pop.
- The wb_* outputs are held stable while wb_valid && !wb_ready. The head does not change until it is popped.
- in_ready depends only on state; there is no combinational path from wb_ready.
- The fwd_* path is combinational from fwd_addr and the registered state.

## Test plan
- Select: push three entries:
  - dsp=1, ern=0, pc_buf=16'h1234 -> head is 16'h1234 with wb_is_stack=1.
  - dsp=1, ern=1, alu_buf=16'h00AA -> 16'h00AA with is_stack=0.
  - mem_load=1, ld_data=16'hBEEF -> 16'hBEEF.
- Fill and stall: hold wb_ready=0 and push 4 entries (DEPTH=4) -> count=4, in_ready=0. A 5th in_valid is ignored. Raise wb_ready -> entries drain in order over 4 cycles and count returns to 0.
- Streaming: in_valid=1 and wb_ready=1 continuously for 20 cycles with incrementing data -> count stays at 1. Output data equals input data delayed by 1 cycle, with no gaps. Pointers wrap correctly.
- Forwarding: queue addr 5 = 16'h1111, addr 7 = 16'h2222, then addr 5 = 16'h3333.
  - fwd_addr=5 -> hit with 16'h3333.
  - fwd_addr=9 -> hit=0, data=0.
  - Pop the first entry -> fwd_addr=5 still returns 16'h3333.
- Reset mid-operation: with 3 entries queued, assert rst for one cycle while in_valid=1 and wb_ready=1 -> the next cycle shows count=0, wb_valid=0, wb_data=0, in_ready=1, and no entry was accepted.
- Empty-push corner: push to an empty queue with wb_ready=1 in the same cycle -> wb_valid=0 in that cycle. The entry pops in the following cycle.
